// File: rtl/store_merge.sv
// Sub-word store unit: byte and halfword stores become a read-modify-write of
// the containing word; aligned word stores go straight to a write.
module store_merge #(
   parameter int unsigned ENDIAN = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        half_q, half_d;
   logic [31:0] wdata_q, wdata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        req_bad;
   logic [1:0]  lane;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [31:0] merged;

   assign req_bad = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   // Big-endian flips the byte lane order within the word.
   always_comb begin
      lane      = (ENDIAN != 0) ? ~addr_q[1:0] : addr_q[1:0];
      lane_mask = 32'h0000_00FF << {lane, 3'b000};
      lane_data = {4{data_q[7:0]}};
      if (half_q) begin
         lane_mask = (addr_q[1] ^ (ENDIAN != 0)) ? 32'hFFFF_0000 : 32'h0000_FFFF;
         lane_data = {2{data_q}};
      end
      merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
   end

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      half_d  = half_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else if (req_size == 2'b10) begin
                  addr_d  = req_addr;
                  wdata_d = req_data;
                  state_d = ST_WRITE;
               end else begin
                  addr_d  = req_addr;
                  data_d  = req_data[15:0];
                  half_d  = req_size[0];
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (mem_ack) begin
               wdata_d = merged;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (mem_ack) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         half_q  <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         half_q  <= half_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign mem_rd    = (state_q == ST_READ);
   assign mem_wr    = (state_q == ST_WRITE);
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
